mic_capture_ctrl: RTL and testbench

//  Sequences the I2S mic receiver: powers it up, discards warm-up samples, then frames left-channel

---
 rtl/mic_capture_pkg.sv | 34 +++
 rtl/mic_capture_ctrl_if.sv | 19 +
 rtl/mic_sample_fifo.sv | 85 ++++++++
 rtl/mic_capture_ctrl.sv | 151 +++++++++++++++
 tb/tb_mic_capture_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mic_capture_pkg.sv
// Shared types and constants for the microphone capture controller.
//   state_t  : controller FSM state (IDLE, WARMUP, CAPTURE, FLUSH)
//   entry_t  : one buffered output word {data, first, last}, 18 bits
//   abs_sat  : magnitude of a signed sample; -32768 saturates to 32767
package mic_capture_pkg;

  localparam int SAMPLE_W           = 16;
  localparam int WARMUP_SAMPLES_DEF = 4096;
  localparam int FRAME_LEN_DEF      = 256;
  localparam int FIFO_DEPTH_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] data;
    logic                first;
    logic                last;
  } entry_t;

  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}})
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (s[SAMPLE_W-1])
      return -s;
    else
      return s;
  endfunction

endpackage

// File: rtl/mic_capture_ctrl_if.sv
// Framed sample stream from the capture controller to feature extraction.
//   m_data[15:0], m_first, m_last, m_valid : source -> sink
//   m_ready                                : sink -> source
// Handshake: a word transfers on a clock edge where m_valid && m_ready.
// Once m_valid is high, m_valid/m_data/m_first/m_last stay unchanged until
// that transfer; m_ready may change freely and never depends on m_valid.
interface mic_capture_ctrl_if;
  import mic_capture_pkg::*;

  logic [SAMPLE_W-1:0] m_data;
  logic                m_first;
  logic                m_last;
  logic                m_valid;
  logic                m_ready;

  modport master (output m_data, m_first, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_first, m_last, m_valid, output m_ready);

endinterface

// File: rtl/mic_sample_fifo.sv
// Synchronous FIFO of entry_t words with a registered output stage.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_en, wr_data     : write request (dropped when full and no pop)
//   drop               : write request rejected this cycle
//   rd_data, rd_valid  : registered head of the queue
//   rd_ready           : consumer accepts rd_data
//   empty              : nothing stored, rd_valid low
// Total capacity (memory + output register) is DEPTH. A write into an
// empty FIFO bypasses the memory and appears on rd_data the next cycle.
module mic_sample_fifo
  import mic_capture_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  entry_t wr_data,
  output logic   drop,
  output entry_t rd_data,
  output logic   rd_valid,
  input  logic   rd_ready,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_cnt;
  logic [AW:0]   occ;
  logic          full;
  logic          pop;
  logic          load_out;
  logic          accept;
  logic          bypass;
  logic          mem_wr;
  logic          mem_rd;

  assign occ      = mem_cnt + {{AW{1'b0}}, rd_valid};
  assign full     = (occ == (AW+1)'(DEPTH));
  assign empty    = (occ == '0);
  assign pop      = rd_valid && rd_ready;
  // Output register is free next cycle if empty now or being drained now.
  assign load_out = !rd_valid || pop;
  // A pop in the same cycle frees a slot, so a push on full still lands.
  assign accept   = wr_en && (!full || pop);
  assign drop     = wr_en && !accept;
  assign mem_rd   = load_out && (mem_cnt != '0);
  assign bypass   = load_out && (mem_cnt == '0) && accept;
  assign mem_wr   = accept && !bypass;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (mem_rd) begin
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
      end else if (bypass) begin
        rd_data  <= wr_data;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mic_capture_ctrl.sv
// Microphone capture sequencer: powers the I2S mic, discards warm-up
// samples, tags left-channel samples into FRAME_LEN frames and buffers
// them onto a valid/ready stream.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, stop           : 1-cycle session control pulses
//   i2s_sample, i2s_valid : samples from the I2S receiver
//   mic_en                : receiver / mic power enable
//   stream (master)       : m_data/m_first/m_last/m_valid/m_ready
//   busy                  : session active (state != IDLE)
//   overflow_cnt          : samples dropped on a full buffer, saturating
//   state                 : current FSM state, for observation
//   peak_level            : only with MIC_CAPTURE_PEAK_EN defined; max
//                           |sample| of the previous complete frame
module mic_capture_ctrl
  import mic_capture_pkg::*;
#(
  parameter int WARMUP_SAMPLES = WARMUP_SAMPLES_DEF,
  parameter int FRAME_LEN      = FRAME_LEN_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [SAMPLE_W-1:0]       i2s_sample,
  input  logic                      i2s_valid,
  output logic                      mic_en,
  mic_capture_ctrl_if.master        stream,
  output logic                      busy,
  output logic [15:0]               overflow_cnt,
  output state_t                    state
`ifdef MIC_CAPTURE_PEAK_EN
  ,
  output logic [SAMPLE_W-1:0]       peak_level
`endif
);

  // +2 keeps the counter at least 1 bit wide when warm-up is disabled.
  localparam int WW = $clog2(WARMUP_SAMPLES + 2);
  localparam int IW = $clog2(FRAME_LEN);

  state_t        state_next;
  logic [WW-1:0] warm_cnt;
  logic [IW-1:0] idx;
  logic          stop_pend;
  logic          last_idx;
  logic          push;
  logic          fifo_drop;
  logic          fifo_empty;
  entry_t        push_entry;
  entry_t        out_entry;

  assign last_idx   = (idx == IW'(FRAME_LEN - 1));
  // Every valid sample in CAPTURE advances the frame index, even when the
  // buffer drops it, so frames stay aligned to real time.
  assign push       = (state == CAPTURE) && i2s_valid;
  assign push_entry = {i2s_sample, idx == '0, last_idx};

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (start && !stop)
          state_next = (WARMUP_SAMPLES == 0) ? CAPTURE : WARMUP;
      WARMUP:
        if (stop)
          state_next = IDLE;
        else if (i2s_valid && (warm_cnt == WW'(WARMUP_SAMPLES - 1)))
          state_next = CAPTURE;
      CAPTURE:
        if (stop && (idx == '0))
          state_next = FLUSH;
        else if ((stop || stop_pend) && i2s_valid && last_idx)
          state_next = FLUSH;
      FLUSH:
        if (fifo_empty)
          state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mic_en       <= 1'b0;
      busy         <= 1'b0;
      warm_cnt     <= '0;
      idx          <= '0;
      stop_pend    <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      state  <= state_next;
      mic_en <= (state_next == WARMUP) || (state_next == CAPTURE);
      busy   <= (state_next != IDLE);

      if (state != WARMUP)  warm_cnt <= '0;
      else if (i2s_valid)   warm_cnt <= warm_cnt + WW'(1);

      if (state != CAPTURE) idx <= '0;
      else if (i2s_valid)   idx <= last_idx ? '0 : idx + IW'(1);

      stop_pend <= (state == CAPTURE) && (stop_pend || stop);

      if (fifo_drop && (overflow_cnt != 16'hFFFF))
        overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  mic_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_data  (push_entry),
    .drop     (fifo_drop),
    .rd_data  (out_entry),
    .rd_valid (stream.m_valid),
    .rd_ready (stream.m_ready),
    .empty    (fifo_empty)
  );

  assign stream.m_data  = out_entry.data;
  assign stream.m_first = out_entry.first;
  assign stream.m_last  = out_entry.last;

`ifdef MIC_CAPTURE_PEAK_EN
  logic [SAMPLE_W-1:0] cur_peak;
  logic [SAMPLE_W-1:0] mag;
  logic [SAMPLE_W-1:0] frame_peak;

  assign mag        = abs_sat(i2s_sample);
  // First sample of a frame restarts the running maximum.
  assign frame_peak = ((idx == '0) || (mag > cur_peak)) ? mag : cur_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_peak   <= '0;
      peak_level <= '0;
    end else if (state == IDLE) begin
      cur_peak   <= '0;
      peak_level <= '0;
    end else if (push) begin
      cur_peak <= frame_peak;
      if (last_idx) peak_level <= frame_peak;
    end
  end
`endif

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl (WARMUP_SAMPLES=3, FRAME_LEN=4,
// FIFO_DEPTH=4). Expected output words are queued when samples are driven
// and compared when the stream transfers them.
module tb_mic_capture_ctrl;
  import mic_capture_pkg::*;

  localparam int W = 3;
  localparam int F = 4;
  localparam int D = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] i2s_sample = '0;
  logic        i2s_valid = 1'b0;
  logic        mic_en;
  logic        busy;
  logic [15:0] overflow_cnt;
  state_t      state;
  logic [15:0] d;
`ifdef MIC_CAPTURE_PEAK_EN
  logic [15:0] peak_level;
`endif

  mic_capture_ctrl_if sif ();

  mic_capture_ctrl #(
    .WARMUP_SAMPLES (W),
    .FRAME_LEN      (F),
    .FIFO_DEPTH     (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .i2s_sample   (i2s_sample),
    .i2s_valid    (i2s_valid),
    .mic_en       (mic_en),
    .stream       (sif),
    .busy         (busy),
    .overflow_cnt (overflow_cnt),
    .state        (state)
`ifdef MIC_CAPTURE_PEAK_EN
    ,
    .peak_level   (peak_level)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s, input bit keep, input bit f, input bit l);
    if (keep) exp_q.push_back({s, f, l});
    i2s_sample = s;
    i2s_valid  = 1'b1;
    tick();
    i2s_valid  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mic_en"},  mic_en, 0);
    chk({tag, "_m_valid"}, sif.m_valid, 0);
    chk({tag, "_m_first"}, sif.m_first, 0);
    chk({tag, "_m_last"},  sif.m_last, 0);
    chk({tag, "_m_data"},  sif.m_data, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_ovf"},     overflow_cnt, 0);
    chk({tag, "_state"},   state, IDLE);
  endtask

  // scoreboard: compare each transferred word with the queue head
  always @(negedge clk) begin
    if (rst_n && sif.m_valid && sif.m_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL out_unexpected observed=%0h expected=none",
               {sif.m_data, sif.m_first, sif.m_last});
      end
      if (exp_q.size() != 0)
        chk("out_word", {14'd0, sif.m_data, sif.m_first, sif.m_last},
            {14'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // 1: warm-up discard, first frame tagging
    sif.m_ready = 1'b1;
    pulse_start();
    chk("t1_mic_en", mic_en, 1);
    chk("t1_busy", busy, 1);
    chk("t1_state", state, WARMUP);
    for (int k = 1; k <= 7; k++) send(16'(k), k >= 4, k == 4, k == 7);
    chk("t1_state_cap", state, CAPTURE);
    wait_drain("t1_drain");

    // 2: three random frames, one-cycle latency
    for (int k = 0; k < 12; k++) begin
      d = 16'($urandom_range(0, 65535));
      send(d, 1'b1, (k % F) == 0, (k % F) == F - 1);
      chk("t2_latency", sif.m_valid, 1);
      tick();
    end
    wait_drain("t2_drain");

    // 3: overflow with a stalled sink, then release
    sif.m_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(16'hA000 + 16'(k), k < 4, k == 0, k == 3);
    chk("t3_overflow", overflow_cnt, 2);
    chk("t3_hold_valid", sif.m_valid, 1);
    chk("t3_hold_data", sif.m_data, 16'hA000);
    sif.m_ready = 1'b1;
    wait_drain("t3_drain");

    // 4: stop mid-frame completes the frame, then flushes
    send(16'hB002, 1'b1, 1'b0, 1'b0);
    send(16'hB003, 1'b1, 1'b0, 1'b1);
    send(16'hC000, 1'b1, 1'b1, 1'b0);
    send(16'hC001, 1'b1, 1'b0, 1'b0);
    pulse_stop();
    chk("t4_pend_state", state, CAPTURE);
    chk("t4_pend_mic_en", mic_en, 1);
    send(16'hC002, 1'b1, 1'b0, 1'b0);
    send(16'hC003, 1'b1, 1'b0, 1'b1);
    chk("t4_mic_off", mic_en, 0);
    chk("t4_flush", state, FLUSH);
    send(16'hC004, 1'b0, 1'b0, 1'b0);
    wait_drain("t4_drain");
    wait_idle("t4_idle");
    chk("t4_state_idle", state, IDLE);
    chk("t4_ovf_kept", overflow_cnt, 2);

    // 5: start+stop together, stop in warm-up, reset mid-capture
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_same_state", state, IDLE);
    chk("t5_same_mic_en", mic_en, 0);
    pulse_start();
    send(16'h0001, 1'b0, 1'b0, 1'b0);
    pulse_stop();
    chk("t5_warm_stop_state", state, IDLE);
    chk("t5_warm_stop_mic", mic_en, 0);
    pulse_start();
    for (int k = 0; k < W; k++) send(16'(k), 1'b0, 1'b0, 1'b0);
    sif.m_ready = 1'b0;
    send(16'hD000, 1'b0, 1'b0, 1'b0);
    send(16'hD001, 1'b0, 1'b0, 1'b0);
    chk("t5_pre_rst_valid", sif.m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_values("t5_rst");
    tick();
    rst_n = 1'b1;
    sif.m_ready = 1'b1;
    repeat (3) tick();
    chk("t5_post_valid", sif.m_valid, 0);
    chk("t5_post_busy", busy, 0);

`ifdef MIC_CAPTURE_PEAK_EN
    // 6: peak of a frame containing -32768
    pulse_start();
    for (int k = 0; k < W; k++) send(16'h7000, 1'b0, 1'b0, 1'b0);
    send(16'h0010, 1'b1, 1'b1, 1'b0);
    send(16'hFF00, 1'b1, 1'b0, 1'b0);
    send(16'h8000, 1'b1, 1'b0, 1'b0);
    chk("t6_peak_before", peak_level, 0);
    send(16'h0005, 1'b1, 1'b0, 1'b1);
    chk("t6_peak", peak_level, 16'h7FFF);
    pulse_stop();
    wait_drain("t6_drain");
    wait_idle("t6_idle");
    tick();
    chk("t6_peak_idle", peak_level, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
